// File: rtl/addsub_stim_driver.sv
// Stimulus driver for add/sub datapaths: issues operand pairs over valid/ready,
// checks each returned result and keeps error, vector and timeout status.
module addsub_stim_driver #(
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      NUM_VECTORS = 16,
    parameter int unsigned      TIMEOUT     = 15,
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(4'h9)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_sub,
    output logic             op_valid,
    input  logic             op_ready,
    input  logic [WIDTH:0]   res_data,
    input  logic             res_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [7:0]       vec_count,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWait,
        StCheck,
        StNext,
        StDone
    } state_e;

    localparam logic [7:0] NumVec   = 8'(NUM_VECTORS);
    localparam logic [7:0] TimerMax = 8'(TIMEOUT);

    state_e         state_q, state_d;
    logic [7:0]     idx_q, idx_d;
    logic [7:0]     timer_q, timer_d;
    logic [WIDTH:0] exp_q, exp_d;
    logic [WIDTH:0] res_q, res_d;
    logic [7:0]     err_q, err_d;
    logic [7:0]     vec_q, vec_d;
    logic           tout_q, tout_d;

    logic [WIDTH-1:0] gen_a, gen_b;
    logic [WIDTH:0]   a_ext, b_ext, exp_calc;
    logic [7:0]       err_inc;
    logic [7:0]       idx_inc;

    // Operands are a pure function of the vector index.
    always_comb begin
        gen_a    = idx_q[WIDTH-1:0] ^ SEED;
        gen_b    = ~idx_q[WIDTH-1:0];
        a_ext    = {1'b0, gen_a};
        b_ext    = {1'b0, gen_b};
        exp_calc = idx_q[0] ? (a_ext - b_ext) : (a_ext + b_ext);
        err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        idx_inc  = idx_q + 8'd1;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        exp_d    = exp_q;
        res_d    = res_q;
        err_d    = err_q;
        vec_d    = vec_q;
        tout_d   = tout_q;
        op_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                done = (state_q == StDone);
                if (start) begin
                    state_d = StSend;
                    idx_d   = '0;
                    err_d   = '0;
                    vec_d   = '0;
                    tout_d  = 1'b0;
                end
            end
            StSend: begin
                busy     = 1'b1;
                op_valid = 1'b1;
                if (op_ready) begin
                    exp_d   = exp_calc;
                    timer_d = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                busy    = 1'b1;
                timer_d = timer_q + 8'd1;
                // A result landing on the timeout cycle takes priority.
                if (res_valid) begin
                    res_d   = res_data;
                    state_d = StCheck;
                end else if (timer_q == TimerMax) begin
                    tout_d  = 1'b1;
                    err_d   = err_inc;
                    state_d = StNext;
                end
            end
            StCheck: begin
                busy = 1'b1;
                if (res_q != exp_q) begin
                    err_d = err_inc;
                end
                state_d = StNext;
            end
            StNext: begin
                busy    = 1'b1;
                vec_d   = vec_q + 8'd1;
                idx_d   = idx_inc;
                state_d = (idx_inc == NumVec) ? StDone : StSend;
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand outputs read zero outside SEND so reset leaves every output at 0.
    always_comb begin
        op_a        = op_valid ? gen_a : '0;
        op_b        = op_valid ? gen_b : '0;
        op_sub      = op_valid & idx_q[0];
        pass        = done & (err_q == 8'd0) & ~tout_q;
        err_count   = err_q;
        vec_count   = vec_q;
        timeout_err = tout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            timer_q <= '0;
            exp_q   <= '0;
            res_q   <= '0;
            err_q   <= '0;
            vec_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
            tout_q  <= tout_d;
        end
    end

endmodule

// File: tb/tb_addsub_stim_driver.sv
// Bench for addsub_stim_driver: plays the unit under test with randomized
// result latency and checks the driver against an arithmetic reference.
module tb_addsub_stim_driver;

    localparam int W  = 4;
    localparam int NV = 16;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         op_sub, op_valid, op_ready;
    logic [W:0]   res_data;
    logic         res_valid;
    logic         busy, done, pass, timeout_err;
    logic [7:0]   err_count, vec_count;

    int tests = 0;
    int fails = 0;

    addsub_stim_driver #(
        .WIDTH      (W),
        .NUM_VECTORS(NV),
        .TIMEOUT    (TO),
        .SEED       (4'h9)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sub     (op_sub),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .vec_count  (vec_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_vec"}, vec_count, 0);
        check({tag, "_tout"}, timeout_err, 0);
        check({tag, "_valid"}, op_valid, 0);
        check({tag, "_ops"}, {op_a, op_b, op_sub}, 0);
    endtask

    // Reference: operands and expected result from plain integer arithmetic.
    function automatic int ref_a(input int i);
        return (i % 16) ^ 9;
    endfunction
    function automatic int ref_b(input int i);
        return 15 - (i % 16);
    endfunction
    function automatic int ref_res(input int i);
        if (i % 2 == 1) return (ref_a(i) - ref_b(i) + 32) % 32;
        return ref_a(i) + ref_b(i);
    endfunction

    // One full run acting as the unit under test.
    task automatic run(input string name, input int stall_vec, input logic [15:0] fault_mask,
                       input int tout_vec, input int bound_vec, input int reset_vec,
                       input bit rand_lat, input bit spur_start);
        int exp_err = 0;
        bit exp_tout = 0;
        int prev_kind = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({name, "_start_busy"}, busy, 1);
        check({name, "_start_done"}, done, 0);
        check({name, "_start_pass"}, pass, 0);
        check({name, "_start_cnt"}, {err_count, vec_count, 7'd0, timeout_err}, 0);

        for (int i = 0; i < NV; i++) begin
            int cnt = 0;
            int d;
            bit got = 0;
            logic [W-1:0] sa, sb;
            logic ss;
            while (cnt < 40 && !got) begin
                @(negedge clk);
                cnt++;
                got = op_valid;
            end
            if (!got) begin
                check({name, "_valid_wait"}, 0, 1);
                return;
            end
            if (prev_kind == 1) check({name, "_latency"}, cnt, 3);
            if (prev_kind == 2) check({name, "_latency_to"}, cnt, 2);
            check({name, "_op_a"}, op_a, ref_a(i));
            check({name, "_op_b"}, op_b, ref_b(i));
            check({name, "_op_sub"}, op_sub, i % 2);

            if (i == stall_vec) begin
                sa = op_a; sb = op_b; ss = op_sub;
                res_valid = 1'b1;  // stray result while sending must be ignored
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1 res_valid = 1'b0;
                    @(negedge clk);
                    check({name, "_stall_valid"}, op_valid, 1);
                    check({name, "_stall_ops"}, {op_a, op_b, op_sub}, {sa, sb, ss});
                end
            end

            op_ready = 1'b1;
            @(posedge clk); #1 op_ready = 1'b0;

            if (i == reset_vec) begin
                check({name, "_pre_rst_err"}, err_count, exp_err);
                check({name, "_pre_rst_vec"}, vec_count, i);
                #2 rst_n = 1'b0;
                #1 check_all_zero({name, "_rst"});
                @(posedge clk); #1 rst_n = 1'b1;
                @(negedge clk);
                check_all_zero({name, "_post_rst"});
                return;
            end

            if (i == tout_vec) begin
                repeat (TO) @(posedge clk);
                @(negedge clk);
                check({name, "_tout_early"}, timeout_err, 0);
                check({name, "_tout_busy"}, busy, 1);
                @(posedge clk); #1;
                exp_err++;
                exp_tout = 1;
                check({name, "_tout_flag"}, timeout_err, 1);
                check({name, "_tout_err"}, err_count, exp_err);
                prev_kind = 2;
            end else begin
                if (i == bound_vec) d = TO + 1;
                else if (rand_lat) d = $urandom_range(1, 4);
                else d = 1;
                if (spur_start && i == 10) begin
                    d = 2;
                    start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                    repeat (d - 2) @(posedge clk);
                end else begin
                    repeat (d - 1) @(posedge clk);
                end
                #1;
                res_valid = 1'b1;
                res_data  = 5'(ref_res(i) ^ (fault_mask[i] ? 1 : 0));
                if (fault_mask[i]) exp_err++;
                @(posedge clk); #1;
                res_valid = 1'b0;
                res_data  = 5'($urandom);
                check({name, "_check_valid"}, op_valid, 0);
                prev_kind = 1;
            end
        end

        begin
            int cnt = 0;
            while (cnt < 10 && !done) begin
                @(negedge clk);
                cnt++;
            end
        end
        check({name, "_done"}, done, 1);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_vec"}, vec_count, NV);
        check({name, "_err"}, err_count, exp_err);
        check({name, "_tout"}, timeout_err, exp_tout);
        check({name, "_pass"}, pass, (exp_err == 0 && !exp_tout) ? 1 : 0);

        // op_ready with op_valid low is meaningless to the driver.
        op_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 op_ready = 1'b0;
        check({name, "_done_hold"}, {done, vec_count}, {1'b1, 8'(NV)});
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        op_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 op_ready = 1'b0;
        check_all_zero("idle_ready");

        run("ideal",    -1, 16'h0000, -1, -1, -1, 1'b0, 1'b0);
        run("bp",        3, 16'h0000, -1, -1, -1, 1'b1, 1'b1);
        run("fault",    -1, 16'h0084, -1, -1, -1, 1'b1, 1'b0);
        run("timeout",  -1, 16'h0000,  4, -1, -1, 1'b1, 1'b0);
        run("boundary", -1, 16'h0000, -1,  9, -1, 1'b1, 1'b0);
        run("rstmid",   -1, 16'h0004, -1, -1,  6, 1'b1, 1'b0);
        run("restart",  -1, 16'h0000, -1, -1, -1, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
